// File: rtl/spike_rate_encoder_pkg.sv
// Shared definitions for the spike encode/decode path: FSM states and
// signed saturation helpers usable at any data width up to 64 bits.
package spike_rate_encoder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    SAT_NONE = 2'd0,
    SAT_POS  = 2'd1,
    SAT_NEG  = 2'd2
  } sat_t;

  // Largest / smallest signed value of a given width, for use in localparams.
  function automatic logic signed [63:0] sat_max(input int width);
    return (64'sd1 <<< (width - 1)) - 64'sd1;
  endfunction

  function automatic logic signed [63:0] sat_min(input int width);
    return -(64'sd1 <<< (width - 1));
  endfunction

  // A (W+1)-bit sum of two W-bit signed operands overflowed iff its top two bits differ.
  function automatic sat_t sat_detect(input logic [1:0] top_bits);
    sat_t kind;
    kind = SAT_NONE;
    if (top_bits == 2'b01) kind = SAT_POS;
    else if (top_bits == 2'b10) kind = SAT_NEG;
    return kind;
  endfunction

endpackage

// File: rtl/spike_if_neuron.sv
// Integrate-and-fire neuron with subtractive reset: holds the membrane,
// performs the saturating integrate, the threshold compare and the subtract.
module spike_if_neuron
  import spike_rate_encoder_pkg::*;
#(
  parameter int DATA_WIDTH = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clear,
  input  logic                         step,
  input  logic signed [DATA_WIDTH-1:0] value,
  input  logic signed [DATA_WIDTH-1:0] threshold,
  output logic                         fire
);

  localparam logic signed [DATA_WIDTH-1:0] SAT_MAX = DATA_WIDTH'(sat_max(DATA_WIDTH));
  localparam logic signed [DATA_WIDTH-1:0] SAT_MIN = DATA_WIDTH'(sat_min(DATA_WIDTH));

  logic signed [DATA_WIDTH-1:0] membrane_reg;
  logic signed [DATA_WIDTH-1:0] membrane_next;
  logic signed [DATA_WIDTH:0]   sum_wide;
  logic signed [DATA_WIDTH:0]   diff_wide;
  logic signed [DATA_WIDTH-1:0] sum_sat;
  logic signed [DATA_WIDTH-1:0] diff_sat;
  logic                         thr_nonpos;

  assign thr_nonpos = threshold[DATA_WIDTH-1] || (threshold == '0);

  always_comb begin
    sum_wide = {membrane_reg[DATA_WIDTH-1], membrane_reg} + {value[DATA_WIDTH-1], value};
    case (sat_detect(sum_wide[DATA_WIDTH:DATA_WIDTH-1]))
      SAT_POS: sum_sat = SAT_MAX;
      SAT_NEG: sum_sat = SAT_MIN;
      default: sum_sat = sum_wide[DATA_WIDTH-1:0];
    endcase

    diff_wide = {sum_sat[DATA_WIDTH-1], sum_sat} - {threshold[DATA_WIDTH-1], threshold};
    case (sat_detect(diff_wide[DATA_WIDTH:DATA_WIDTH-1]))
      SAT_POS: diff_sat = SAT_MAX;
      SAT_NEG: diff_sat = SAT_MIN;
      default: diff_sat = diff_wide[DATA_WIDTH-1:0];
    endcase
  end

  // A non-positive threshold fires every step and pins the membrane at zero.
  always_comb begin
    fire          = thr_nonpos || (sum_sat >= threshold);
    membrane_next = sum_sat;
    if (thr_nonpos) membrane_next = '0;
    else if (fire) membrane_next = diff_sat;
  end

  always_ff @(posedge clk) begin
    if (rst || clear) membrane_reg <= '0;
    else if (step) membrane_reg <= membrane_next;
  end

endmodule

// File: rtl/spike_rate_encoder.sv
// Rate-codes a signed activation into a spike train of programmable length,
// one timestep per shared step_en strobe.
module spike_rate_encoder
  import spike_rate_encoder_pkg::*;
#(
  parameter int DATA_WIDTH     = 16,
  parameter int TIMESTEP_WIDTH = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [DATA_WIDTH-1:0]     in_value,
  input  logic [DATA_WIDTH-1:0]     threshold,
  input  logic [TIMESTEP_WIDTH-1:0] num_timesteps,
  input  logic                      step_en,
  output logic                      spike,
  output logic                      spike_valid,
  output logic                      busy,
  output logic                      done,
  output logic [TIMESTEP_WIDTH-1:0] spike_count
);

  state_t                       state_reg;
  logic signed [DATA_WIDTH-1:0] value_reg;
  logic signed [DATA_WIDTH-1:0] threshold_reg;
  logic [TIMESTEP_WIDTH-1:0]    num_steps_reg;
  logic [TIMESTEP_WIDTH-1:0]    step_cnt_reg;
  logic [TIMESTEP_WIDTH-1:0]    spike_count_reg;
  logic                         spike_reg;
  logic                         spike_valid_reg;
  logic                         busy_reg;
  logic                         done_reg;
  logic                         in_ready_reg;

  logic accept;
  logic step_run;
  logic last_step;
  logic fire;

  assign accept    = in_valid && (state_reg == ST_IDLE);
  assign step_run  = step_en && (state_reg == ST_RUN);
  assign last_step = (step_cnt_reg == num_steps_reg - TIMESTEP_WIDTH'(1));

  spike_if_neuron #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_neuron (
    .clk      (clk),
    .rst      (rst),
    .clear    (accept),
    .step     (step_run),
    .value    (value_reg),
    .threshold(threshold_reg),
    .fire     (fire)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= ST_IDLE;
      value_reg       <= '0;
      threshold_reg   <= '0;
      num_steps_reg   <= '0;
      step_cnt_reg    <= '0;
      spike_count_reg <= '0;
      spike_reg       <= 1'b0;
      spike_valid_reg <= 1'b0;
      busy_reg        <= 1'b0;
      done_reg        <= 1'b0;
      in_ready_reg    <= 1'b1;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          spike_valid_reg <= 1'b0;
          if (in_valid) begin
            value_reg       <= in_value;
            threshold_reg   <= threshold;
            num_steps_reg   <= num_timesteps;
            step_cnt_reg    <= '0;
            spike_count_reg <= '0;
            spike_reg       <= 1'b0;
            in_ready_reg    <= 1'b0;
            if (num_timesteps == '0) begin
              state_reg <= ST_DONE;
              done_reg  <= 1'b1;
            end else begin
              state_reg <= ST_RUN;
              busy_reg  <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          spike_valid_reg <= step_en;
          if (step_en) begin
            spike_reg    <= fire;
            step_cnt_reg <= step_cnt_reg + TIMESTEP_WIDTH'(1);
            if (fire && (spike_count_reg != '1))
              spike_count_reg <= spike_count_reg + TIMESTEP_WIDTH'(1);
            if (last_step) begin
              state_reg <= ST_DONE;
              busy_reg  <= 1'b0;
              done_reg  <= 1'b1;
            end
          end
        end
        ST_DONE: begin
          state_reg       <= ST_IDLE;
          done_reg        <= 1'b0;
          spike_valid_reg <= 1'b0;
          in_ready_reg    <= 1'b1;
        end
        default: begin
          state_reg       <= ST_IDLE;
          busy_reg        <= 1'b0;
          done_reg        <= 1'b0;
          spike_valid_reg <= 1'b0;
          in_ready_reg    <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready    = in_ready_reg;
  assign spike       = spike_reg;
  assign spike_valid = spike_valid_reg;
  assign busy        = busy_reg;
  assign done        = done_reg;
  assign spike_count = spike_count_reg;

endmodule

// File: tb/tb_spike_rate_encoder.sv
// Self-checking bench for spike_rate_encoder: directed jobs plus randomized
// jobs, checked against an integer integrate-and-fire reference model.
module tb_spike_rate_encoder;

  localparam int DW = 16;
  localparam int TW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_value;
  logic [DW-1:0] threshold;
  logic [TW-1:0] num_timesteps;
  logic          step_en;
  logic          spike;
  logic          spike_valid;
  logic          busy;
  logic          done;
  logic [TW-1:0] spike_count;

  int n_cmp = 0;
  int n_mis = 0;
  bit exp_q[$];
  int exp_cnt;

  always #5 clk = ~clk;

  spike_rate_encoder #(
    .DATA_WIDTH(DW),
    .TIMESTEP_WIDTH(TW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_value(in_value),
    .threshold(threshold),
    .num_timesteps(num_timesteps),
    .step_en(step_en),
    .spike(spike),
    .spike_valid(spike_valid),
    .busy(busy),
    .done(done),
    .spike_count(spike_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_mis++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int clamp16(input int x);
    if (x > 32767) return 32767;
    if (x < -32768) return -32768;
    return x;
  endfunction

  // Reference: plain integer integrate-and-fire over t steps from membrane 0.
  task automatic model(input int v, input int thr, input int t);
    int m;
    int s;
    m = 0;
    exp_q.delete();
    exp_cnt = 0;
    for (int i = 0; i < t; i++) begin
      s = clamp16(m + v);
      if (thr <= 0) begin
        exp_q.push_back(1'b1);
        m = 0;
      end else if (s >= thr) begin
        exp_q.push_back(1'b1);
        m = clamp16(s - thr);
      end else begin
        exp_q.push_back(1'b0);
        m = s;
      end
    end
    foreach (exp_q[i]) if (exp_q[i]) exp_cnt++;
    if (exp_cnt > 255) exp_cnt = 255;
  endtask

  function automatic logic pick_step(input int mode, input int cyc);
    logic [6:0] pat;
    pat = 7'b1011001;
    if (mode == 0) return 1'b1;
    if (mode == 1) return 1'($urandom_range(0, 1));
    if (cyc < 7) return pat[cyc];
    return 1'b1;
  endfunction

  // One complete job, observed at negedges; inputs change at negedges too.
  task automatic run_job(input int v, input int thr, input int t, input int mode, input bit poke);
    int  idx;
    int  cyc;
    logic prev;
    model(v, thr, t);
    chk("idle_ready", 32'(in_ready), 1);
    in_valid      = 1'b1;
    in_value      = v[DW-1:0];
    threshold     = thr[DW-1:0];
    num_timesteps = t[TW-1:0];
    step_en       = 1'($urandom_range(0, 1));
    @(negedge clk);
    in_valid = poke;
    in_value = 16'($urandom);
    if (t == 0) begin
      chk("t0_done", 32'(done), 1);
      chk("t0_ready", 32'(in_ready), 0);
      chk("t0_busy", 32'(busy), 0);
      chk("t0_svalid", 32'(spike_valid), 0);
      chk("t0_count", 32'(spike_count), 0);
      in_valid = 1'b0;
      step_en  = 1'b0;
      @(negedge clk);
      chk("t0_done_end", 32'(done), 0);
      chk("t0_ready_end", 32'(in_ready), 1);
      chk("t0_svalid_end", 32'(spike_valid), 0);
      $display("job v=%0d thr=%0d T=%0d spikes=%0d/%0d", v, thr, t, spike_count, exp_cnt);
      return;
    end
    chk("run_busy", 32'(busy), 1);
    chk("run_ready", 32'(in_ready), 0);
    chk("run_svalid0", 32'(spike_valid), 0);
    chk("run_count0", 32'(spike_count), 0);
    idx = 0;
    cyc = 0;
    while (idx < t && cyc < 2000) begin
      step_en = pick_step(mode, cyc);
      prev    = step_en;
      @(negedge clk);
      cyc++;
      if (prev) begin
        chk("svalid_on", 32'(spike_valid), 1);
        chk("spike_bit", 32'(spike), 32'(exp_q[idx]));
        idx++;
        chk("done_at_step", 32'(done), 32'(idx == t));
        chk("busy_at_step", 32'(busy), 32'(idx != t));
      end else begin
        chk("svalid_off", 32'(spike_valid), 0);
        chk("done_idle_step", 32'(done), 0);
        chk("busy_hold", 32'(busy), 1);
      end
    end
    if (idx < t) chk("job_timeout", 32'(idx), 32'(t));
    step_en  = 1'b0;
    in_valid = 1'b0;
    chk("done_count", 32'(spike_count), 32'(exp_cnt));
    chk("done_ready", 32'(in_ready), 0);
    @(negedge clk);
    chk("post_done", 32'(done), 0);
    chk("post_svalid", 32'(spike_valid), 0);
    chk("post_ready", 32'(in_ready), 1);
    chk("post_count", 32'(spike_count), 32'(exp_cnt));
    $display("job v=%0d thr=%0d T=%0d spikes=%0d/%0d", v, thr, t, spike_count, exp_cnt);
  endtask

  initial begin
    rst           = 1'b1;
    in_valid      = 1'b0;
    in_value      = '0;
    threshold     = '0;
    num_timesteps = '0;
    step_en       = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_spike", 32'(spike), 0);
    chk("rst_svalid", 32'(spike_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_count", 32'(spike_count), 0);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_ready", 32'(in_ready), 1);

    run_job(64, 256, 8, 0, 1'b0);
    run_job(256, 256, 4, 0, 1'b0);
    run_job(32767, 32767, 3, 0, 1'b0);
    run_job(-10, 100, 5, 0, 1'b0);
    run_job(-10, 0, 5, 0, 1'b0);
    run_job(-32768, 100, 4, 1, 1'b0);
    run_job(500, 100, 0, 0, 1'b0);
    run_job(100, 150, 4, 2, 1'b1);

    // Abort a job after two of six steps.
    in_valid      = 1'b1;
    in_value      = 16'd100;
    threshold     = 16'd150;
    num_timesteps = 8'd6;
    @(negedge clk);
    in_valid = 1'b0;
    step_en  = 1'b1;
    repeat (2) @(negedge clk);
    chk("abort_svalid_pre", 32'(spike_valid), 1);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_spike", 32'(spike), 0);
    chk("abort_svalid", 32'(spike_valid), 0);
    chk("abort_busy", 32'(busy), 0);
    chk("abort_done", 32'(done), 0);
    chk("abort_count", 32'(spike_count), 0);
    chk("abort_ready", 32'(in_ready), 1);
    rst     = 1'b0;
    step_en = 1'b0;
    @(negedge clk);
    chk("abort_no_done", 32'(done), 0);
    $display("abort after 2 steps checked");
    run_job(100, 150, 4, 0, 1'b0);

    for (int j = 0; j < 24; j++) begin
      int v;
      int thr;
      if (j % 2 == 0) begin
        v   = int'($urandom_range(0, 65535)) - 32768;
        thr = int'($urandom_range(0, 65535)) - 32768;
      end else begin
        v   = int'($urandom_range(0, 600)) - 100;
        thr = int'($urandom_range(0, 700)) - 50;
      end
      run_job(v, thr, int'($urandom_range(0, 12)), int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
